// File: rtl/pll_ctrl_pkg.sv
// Shared types and constants for the PLL reset sequencer.
// Holds the state encoding, the output decode and the cycle constants.
package pll_ctrl_pkg;

  typedef enum logic [2:0] {
    HOLD_RST  = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RUN       = 3'd3,
    FAILED    = 3'd4
  } state_t;

  localparam int RETRY_W = 4;

  localparam int DEF_RESETB_HOLD  = 16;
  localparam int DEF_LOCK_STABLE  = 64;
  localparam int DEF_LOCK_TIMEOUT = 2048;
  localparam int DEF_MAX_RETRIES  = 3;
  localparam int DEF_CNT_W        = 12;

  localparam int TP_RESETB_HOLD  = 4;
  localparam int TP_LOCK_STABLE  = 8;
  localparam int TP_LOCK_TIMEOUT = 32;
  localparam int TP_MAX_RETRIES  = 3;

  typedef struct packed {
    logic resetb;
    logic sys_reset;
    logic ready;
    logic fail;
  } pll_out_t;

  function automatic pll_out_t decode(input state_t s);
    pll_out_t o;
    o = '{resetb: 1'b0, sys_reset: 1'b1,
          ready: 1'b0, fail: 1'b0};
    case (s)
      WAIT_LOCK,
      STABLE:  o.resetb = 1'b1;
      RUN: begin
        o.resetb    = 1'b1;
        o.sys_reset = 1'b0;
        o.ready     = 1'b1;
      end
      FAILED:  o.fail = 1'b1;
      default: o.resetb = 1'b0;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/pll_reset_sequencer_sync_2ff.sv
// Generic two-flop bit synchronizer.
// Asynchronous active-high clear forces both stages low.
module sync_2ff (
  input  logic clk,
  input  logic clr,
  input  logic d,
  output logic q
);

  logic meta;

  // Two-stage capture of an asynchronous bit.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_reset_sequencer.sv
// PLL power-up and lock supervision sequencer.
// Drives PLL RESETB, waits for stable lock, then releases SYS_RESET.
module pll_reset_sequencer
  import pll_ctrl_pkg::*;
#(
  parameter int RESETB_HOLD_CYCLES  = DEF_RESETB_HOLD,
  parameter int LOCK_STABLE_CYCLES  = DEF_LOCK_STABLE,
  parameter int LOCK_TIMEOUT_CYCLES = DEF_LOCK_TIMEOUT,
  parameter int MAX_RETRIES         = DEF_MAX_RETRIES,
  parameter int CNT_W               = DEF_CNT_W
) (
  input  logic               REFERENCECLK,
  input  logic               RESET,
  input  logic               PLL_LOCK,
  input  logic               RESTART,
  output logic               PLL_RESETB,
  output logic               PLL_BYPASS,
  output logic               SYS_RESET,
  output logic               READY,
  output logic               FAIL,
  output logic [RETRY_W-1:0] RETRY_COUNT
);

  // The WAIT_LOCK cycle that sees lock_s high is the first stable
  // cycle, so STABLE itself only has to cover the remaining ones.
  localparam bit ST_DIRECT = (LOCK_STABLE_CYCLES <= 1);

  localparam logic [CNT_W-1:0] HOLD_LD =
    CNT_W'(RESETB_HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LD =
    CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] ST_LD =
    ST_DIRECT ? '0 : CNT_W'(LOCK_STABLE_CYCLES - 2);
  localparam logic [RETRY_W-1:0] RETRY_MAX =
    RETRY_W'(MAX_RETRIES);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [RETRY_W-1:0] retry_q, retry_d;
  pll_out_t           out_q;
  logic               lock_s;
  logic               cnt_zero;

  sync_2ff u_lock_sync (
    .clk (REFERENCECLK),
    .clr (RESET),
    .d   (PLL_LOCK),
    .q   (lock_s)
  );

  assign cnt_zero = (cnt_q == '0);

  // State, counter, retry count and decoded outputs.
  always_ff @(posedge REFERENCECLK or posedge RESET) begin
    if (RESET) begin
      state_q <= HOLD_RST;
      cnt_q   <= HOLD_LD;
      retry_q <= '0;
      out_q   <= decode(HOLD_RST);
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      retry_q <= retry_d;
      out_q   <= decode(state_d);
    end
  end

  // Next-state, counter reload and retry bookkeeping.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    retry_d = retry_q;
    if (RESTART) begin
      state_d = HOLD_RST;
      cnt_d   = HOLD_LD;
      retry_d = '0;
    end else begin
      unique case (state_q)
        HOLD_RST: begin
          if (cnt_zero) begin
            state_d = WAIT_LOCK;
            cnt_d   = TO_LD;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        WAIT_LOCK: begin
          if (lock_s) begin
            if (ST_DIRECT) begin
              state_d = RUN;
              cnt_d   = '0;
              retry_d = '0;
            end else begin
              state_d = STABLE;
              cnt_d   = ST_LD;
            end
          end else if (cnt_zero) begin
            retry_d = retry_q + RETRY_W'(1);
            cnt_d   = HOLD_LD;
            if (retry_d == RETRY_MAX)
              state_d = FAILED;
            else
              state_d = HOLD_RST;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        STABLE: begin
          if (!lock_s) begin
            state_d = WAIT_LOCK;
            cnt_d   = TO_LD;
          end else if (cnt_zero) begin
            state_d = RUN;
            cnt_d   = '0;
            retry_d = '0;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        RUN: begin
          if (!lock_s) begin
            state_d = HOLD_RST;
            cnt_d   = HOLD_LD;
          end
        end
        FAILED: begin
          state_d = FAILED;
        end
        default: begin
          state_d = HOLD_RST;
          cnt_d   = HOLD_LD;
        end
      endcase
    end
  end

  assign PLL_RESETB  = out_q.resetb;
  assign SYS_RESET   = out_q.sys_reset;
  assign READY       = out_q.ready;
  assign FAIL        = out_q.fail;
  assign PLL_BYPASS  = 1'b0;
  assign RETRY_COUNT = retry_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed bench for the PLL reset sequencer.
// Small cycle constants keep every sequence short.
module tb_pll_reset_sequencer;
  import pll_ctrl_pkg::*;

  logic               clk = 1'b0;
  logic               rst;
  logic               lock;
  logic               restart;
  logic               resetb;
  logic               bypass;
  logic               sys_reset;
  logic               ready;
  logic               fail;
  logic [RETRY_W-1:0] retry;

  int n_cmp = 0;
  int n_err = 0;
  int n;

  pll_reset_sequencer #(
    .RESETB_HOLD_CYCLES  (TP_RESETB_HOLD),
    .LOCK_STABLE_CYCLES  (TP_LOCK_STABLE),
    .LOCK_TIMEOUT_CYCLES (TP_LOCK_TIMEOUT),
    .MAX_RETRIES         (TP_MAX_RETRIES),
    .CNT_W               (12)
  ) dut (
    .REFERENCECLK (clk),
    .RESET        (rst),
    .PLL_LOCK     (lock),
    .RESTART      (restart),
    .PLL_RESETB   (resetb),
    .PLL_BYPASS   (bypass),
    .SYS_RESET    (sys_reset),
    .READY        (ready),
    .FAIL         (fail),
    .RETRY_COUNT  (retry)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs,
                     input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d",
             tag, obs, exp);
    end
  endtask

  // sel 0 watches PLL_RESETB, sel 1 watches SYS_RESET.
  task automatic wait_for(input int sel, input logic val,
                          output int cnt);
    logic s;
    cnt = 0;
    s = (sel == 0) ? resetb : sys_reset;
    while (s !== val && cnt < 200) begin
      tick;
      cnt++;
      s = (sel == 0) ? resetb : sys_reset;
    end
  endtask

  initial begin
    rst = 1'b1;
    lock = 1'b0;
    restart = 1'b0;
    tick;
    tick;
    chk("rst_resetb", int'(resetb), 0);
    chk("rst_sysrst", int'(sys_reset), 1);
    chk("rst_ready", int'(ready), 0);
    chk("rst_fail", int'(fail), 0);
    chk("rst_retry", int'(retry), 0);
    chk("bypass", int'(bypass), 0);

    // Nominal start.
    rst = 1'b0;
    wait_for(0, 1'b1, n);
    chk("nom_hold", n, 4);
    repeat (6) tick;
    lock = 1'b1;
    wait_for(1, 1'b0, n);
    chk("nom_release", n, 10);
    chk("nom_ready", int'(ready), 1);
    chk("nom_retry", int'(retry), 0);

    // Lock loss in RUN.
    tick;
    lock = 1'b0;
    wait_for(1, 1'b1, n);
    chk("loss_latency", n, 3);
    chk("loss_ready", int'(ready), 0);
    chk("loss_resetb", int'(resetb), 0);
    wait_for(0, 1'b1, n);
    chk("loss_hold", n, 4);
    lock = 1'b1;
    wait_for(1, 1'b0, n);
    chk("relock_release", n, 10);
    chk("relock_ready", int'(ready), 1);

    // Lock glitch while in STABLE.
    lock = 1'b0;
    wait_for(1, 1'b1, n);
    wait_for(0, 1'b1, n);
    lock = 1'b1;
    repeat (7) tick;
    chk("glitch_pre_sys", int'(sys_reset), 1);
    lock = 1'b0;
    tick;
    lock = 1'b1;
    repeat (3) tick;
    chk("glitch_resetb", int'(resetb), 1);
    chk("glitch_retry", int'(retry), 0);
    wait_for(1, 1'b0, n);
    chk("glitch_release", n, 7);

    // Asynchronous reset in the middle of STABLE.
    lock = 1'b0;
    wait_for(1, 1'b1, n);
    wait_for(0, 1'b1, n);
    lock = 1'b1;
    repeat (4) tick;
    #2;
    rst = 1'b1;
    #1;
    chk("arst_resetb", int'(resetb), 0);
    chk("arst_sysrst", int'(sys_reset), 1);
    chk("arst_retry", int'(retry), 0);
    tick;
    tick;
    rst = 1'b0;
    wait_for(0, 1'b1, n);
    chk("arst_hold", n, 4);
    wait_for(1, 1'b0, n);
    chk("arst_release", n, 8);

    // Lock never rises.
    restart = 1'b1;
    lock = 1'b0;
    tick;
    restart = 1'b0;
    chk("rs_sysrst", int'(sys_reset), 1);
    for (int i = 1; i <= 3; i++) begin
      wait_for(0, 1'b1, n);
      chk("nl_low", n, 4);
      wait_for(0, 1'b0, n);
      chk("nl_high", n, 32);
      chk("nl_retry", int'(retry), i);
    end
    chk("nl_fail", int'(fail), 1);
    repeat (50) tick;
    chk("nl_fail_held", int'(fail), 1);
    chk("nl_resetb_held", int'(resetb), 0);
    restart = 1'b1;
    tick;
    restart = 1'b0;
    chk("rs_fail", int'(fail), 0);
    chk("rs_retry", int'(retry), 0);
    wait_for(0, 1'b1, n);
    chk("rs_hold", n, 4);

    // Lock reaches the FSM on the timeout edge.
    repeat (29) tick;
    lock = 1'b1;
    repeat (3) tick;
    chk("edge_resetb", int'(resetb), 1);
    chk("edge_retry", int'(retry), 0);
    wait_for(1, 1'b0, n);
    chk("edge_release", n, 7);

    // RESTART during HOLD_RST restarts the hold count.
    restart = 1'b1;
    tick;
    restart = 1'b0;
    tick;
    tick;
    restart = 1'b1;
    tick;
    restart = 1'b0;
    wait_for(0, 1'b1, n);
    chk("rehold", n, 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
